// File: rtl/fifo_packer_pkg.sv
// Shared types and default geometry for the FIFO word packer.
// Optional partial-beat flush is enabled with macro FIFO_PACKER_FLUSH_EN.
package fifo_packer_pkg;

  localparam int unsigned SIZE_DEF     = 4;
  localparam int unsigned PACK_IDX_DEF = 2;
  localparam int unsigned PACK         = 2 ** PACK_IDX_DEF;

  // Accumulator occupancy: EMPTY (0 words), PARTIAL (1..PACK-1), FULL (PACK)
  typedef enum logic [1:0] {
    ACC_EMPTY   = 2'd0,
    ACC_PARTIAL = 2'd1,
    ACC_FULL    = 2'd2
  } acc_state_e;

endpackage

// File: rtl/fifo_packer_out_reg.sv
// One-entry valid/ready pipeline register holding the packed output beat.
module pack_out_reg
  import fifo_packer_pkg::*;
#(
  parameter int unsigned W = SIZE_DEF * PACK
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_val,
  output logic         in_rdy,
  input  logic [W-1:0] in_data,
  output logic         out_val,
  input  logic         out_rdy,
  output logic [W-1:0] out_data
);

  logic         val_q, val_d;
  logic [W-1:0] data_q, data_d;

  // Register is free when empty or being drained this cycle
  assign in_rdy   = !val_q || out_rdy;
  assign out_val  = val_q;
  assign out_data = data_q;

  // Load a new entry when free; payload only changes on a load
  always_comb begin
    val_d  = val_q;
    data_d = data_q;
    if (in_rdy) begin
      val_d = in_val;
      if (in_val) data_d = in_data;
    end
  end

  // Entry state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      val_q  <= 1'b0;
      data_q <= '0;
    end else begin
      val_q  <= val_d;
      data_q <= data_d;
    end
  end

endmodule

// File: rtl/fifo_packer.sv
// Packs 2**PACK_IDX narrow FIFO words into one wide beat, first word in the LSBs.
// Define FIFO_PACKER_FLUSH_EN to add the flush input and out_cnt output for partial beats.
module fifo_packer
  import fifo_packer_pkg::*;
#(
  parameter int unsigned SIZE     = SIZE_DEF,
  parameter int unsigned PACK_IDX = PACK_IDX_DEF
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_val,
  output logic                           in_rdy,
  input  logic [SIZE-1:0]                in_data,
  output logic                           out_val,
  input  logic                           out_rdy,
`ifdef FIFO_PACKER_FLUSH_EN
  input  logic                           flush,
  output logic [PACK_IDX:0]              out_cnt,
`endif
  output logic [SIZE*(2**PACK_IDX)-1:0]  out_data
);

  localparam int unsigned LANES  = 2 ** PACK_IDX;
  localparam int unsigned CNT_W  = PACK_IDX + 1;
  localparam int unsigned DATA_W = SIZE * LANES;
`ifdef FIFO_PACKER_FLUSH_EN
  localparam int unsigned REG_W  = DATA_W + CNT_W;
`else
  localparam int unsigned REG_W  = DATA_W;
`endif

  acc_state_e                 state_q, state_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d, cnt_nxt;
  logic [LANES-1:0][SIZE-1:0] lanes_q, lanes_d, lanes_nxt;
  logic                       in_hsk;
  logic                       reg_free;
  logic                       beat_full;
  logic                       load;
  logic [REG_W-1:0]           beat_pl;
  logic [REG_W-1:0]           reg_pl;
`ifdef FIFO_PACKER_FLUSH_EN
  logic                       pend_q, pend_d;
  logic                       flush_req;
`endif

  // Ready depends on accumulator state only, never on out_rdy
`ifdef FIFO_PACKER_FLUSH_EN
  assign in_rdy = (state_q != ACC_FULL) && !pend_q;
`else
  assign in_rdy = (state_q != ACC_FULL);
`endif
  assign in_hsk = in_val && in_rdy;

  // Accumulate words and decide when a beat moves into the output register
  always_comb begin
    lanes_nxt = lanes_q;
    cnt_nxt   = cnt_q;
    beat_full = 1'b0;
    load      = 1'b0;
    cnt_d     = cnt_q;
    lanes_d   = lanes_q;
    state_d   = state_q;
`ifdef FIFO_PACKER_FLUSH_EN
    pend_d    = 1'b0;
    flush_req = flush || pend_q;
`endif

    if (in_hsk) begin
      lanes_nxt[cnt_q[PACK_IDX-1:0]] = in_data;
      cnt_nxt                        = cnt_q + CNT_W'(1);
    end

    beat_full = (cnt_nxt == CNT_W'(LANES));
    load      = beat_full;
`ifdef FIFO_PACKER_FLUSH_EN
    // A flush with nothing accumulated is ignored
    load      = beat_full || (flush_req && (cnt_nxt != '0));
`endif

    cnt_d   = cnt_nxt;
    lanes_d = lanes_nxt;
    if (load && reg_free) begin
      // Lanes are cleared so a later partial beat carries zeros above its count
      cnt_d   = '0;
      lanes_d = '0;
    end
`ifdef FIFO_PACKER_FLUSH_EN
    if (load && !reg_free && !beat_full) pend_d = 1'b1;
`endif

    if (cnt_d == '0)                     state_d = ACC_EMPTY;
    else if (cnt_d == CNT_W'(LANES))     state_d = ACC_FULL;
    else                                 state_d = ACC_PARTIAL;
  end

`ifdef FIFO_PACKER_FLUSH_EN
  assign beat_pl  = {cnt_nxt, lanes_nxt};
  assign out_data = reg_pl[DATA_W-1:0];
  assign out_cnt  = reg_pl[REG_W-1:DATA_W];
`else
  assign beat_pl  = lanes_nxt;
  assign out_data = reg_pl;
`endif

  // Accumulator state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ACC_EMPTY;
      cnt_q   <= '0;
      lanes_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lanes_q <= lanes_d;
    end
  end

`ifdef FIFO_PACKER_FLUSH_EN
  // Flush waiting for the output register to drain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pend_q <= 1'b0;
    else     pend_q <= pend_d;
  end
`endif

  pack_out_reg #(
    .W (REG_W)
  ) u_out_reg (
    .clk      (clk),
    .rst      (rst),
    .in_val   (load),
    .in_rdy   (reg_free),
    .in_data  (beat_pl),
    .out_val  (out_val),
    .out_rdy  (out_rdy),
    .out_data (reg_pl)
  );

endmodule

// File: tb/tb_fifo_packer.sv
// Directed self-checking bench for fifo_packer (SIZE=4, PACK_IDX=2).
// Flush checks are included when FIFO_PACKER_FLUSH_EN is defined.
module tb_fifo_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_val;
  logic        in_rdy;
  logic [3:0]  in_data;
  logic        out_val;
  logic        out_rdy;
  logic [15:0] out_data;
`ifdef FIFO_PACKER_FLUSH_EN
  logic        flush;
  logic [2:0]  out_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int beats;

  fifo_packer #(.SIZE(4), .PACK_IDX(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_val   (in_val),
    .in_rdy   (in_rdy),
    .in_data  (in_data),
    .out_val  (out_val),
    .out_rdy  (out_rdy),
`ifdef FIFO_PACKER_FLUSH_EN
    .flush    (flush),
    .out_cnt  (out_cnt),
`endif
    .out_data (out_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] d);
    in_val  = 1'b1;
    in_data = d;
    step();
    in_val  = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] exp_beats [3];
    exp_beats[0] = 16'h4321;
    exp_beats[1] = 16'h8765;
    exp_beats[2] = 16'hCBA9;

    rst = 1'b1; in_val = 1'b0; in_data = '0; out_rdy = 1'b0;
`ifdef FIFO_PACKER_FLUSH_EN
    flush = 1'b0;
`endif
    #2;
    chk("rst_out_val", 32'(out_val), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'h0);
`ifdef FIFO_PACKER_FLUSH_EN
    chk("rst_out_cnt", 32'(out_cnt), 32'd0);
`endif
    step(); step();
    rst = 1'b0;
    chk("post_rst_in_rdy", 32'(in_rdy), 32'd1);

    // Four words back-to-back, drained continuously
    out_rdy = 1'b1;
    push(4'h1); push(4'h2); push(4'h3);
    chk("b2b_not_yet", 32'(out_val), 32'd0);
    push(4'h4);
    chk("b2b_out_val", 32'(out_val), 32'd1);
    chk("b2b_out_data", 32'(out_data), 32'h4321);
    chk("b2b_in_rdy", 32'(in_rdy), 32'd1);
    step();
    chk("b2b_drained", 32'(out_val), 32'd0);

    // Backpressure: eight words fill register and accumulator
    out_rdy = 1'b0;
    for (int i = 1; i <= 8; i++) push(4'(i));
    chk("bp_in_rdy_low", 32'(in_rdy), 32'd0);
    chk("bp_out_val", 32'(out_val), 32'd1);
    chk("bp_beat0", 32'(out_data), 32'h4321);
    in_val = 1'b1; in_data = 4'h9;
    step(); step();
    chk("bp_still_blocked", 32'(in_rdy), 32'd0);
    chk("bp_stable", 32'(out_data), 32'h4321);
    out_rdy = 1'b1;
    step();
    chk("bp_beat1_val", 32'(out_val), 32'd1);
    chk("bp_beat1", 32'(out_data), 32'h8765);
    chk("bp_in_rdy_back", 32'(in_rdy), 32'd1);
    step();
    in_val = 1'b0;
    chk("bp_beat1_gone", 32'(out_val), 32'd0);
    push(4'hA); push(4'hB); push(4'hC);
    chk("bp_word9_beat_val", 32'(out_val), 32'd1);
    chk("bp_word9_beat", 32'(out_data), 32'hCBA9);
    step();
    chk("bp_final_drain", 32'(out_val), 32'd0);

    // Streaming: twelve words, one per cycle, no bubble
    beats = 0;
    for (int k = 1; k <= 12; k++) begin
      in_val  = 1'b1;
      in_data = 4'(k);
      chk($sformatf("stream_in_rdy_%0d", k), 32'(in_rdy), 32'd1);
      step();
      chk($sformatf("stream_out_val_%0d", k), 32'(out_val), 32'((k % 4) == 0));
      if (out_val) begin
        if (beats < 3) chk($sformatf("stream_beat_%0d", beats), 32'(out_data), 32'(exp_beats[beats]));
        beats++;
      end
    end
    in_val = 1'b0;
    step();
    chk("stream_beat_count", 32'(beats), 32'd3);
    chk("stream_idle", 32'(out_val), 32'd0);

`ifdef FIFO_PACKER_FLUSH_EN
    // Partial beat via flush, then flush on an empty accumulator
    push(4'hA); push(4'hB); push(4'hC);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_val", 32'(out_val), 32'd1);
    chk("flush_data", 32'(out_data), 32'h0CBA);
    chk("flush_cnt", 32'(out_cnt), 32'd3);
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_empty_no_beat", 32'(out_val), 32'd0);
`endif

    // Mid-operation reset clears output and partial lanes
    out_rdy = 1'b0;
    for (int i = 1; i <= 6; i++) push(4'(i));
    chk("pre_rst_out_val", 32'(out_val), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_out_val", 32'(out_val), 32'd0);
    chk("mid_rst_out_data", 32'(out_data), 32'h0);
    step();
    rst = 1'b0;
    out_rdy = 1'b1;
    push(4'hD); push(4'hE); push(4'hF); push(4'h1);
    chk("post_rst_beat_val", 32'(out_val), 32'd1);
    chk("post_rst_beat", 32'(out_data), 32'h1FED);
    step();
    chk("post_rst_drain", 32'(out_val), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
